ad9958_ramp_gen: RTL
====================

Name: ad9958_ramp_gen

Overview:
Upstream stimulus stage for the AD9958 master. Generates stepped linear frequency ramps on both DDS channels and drives the master's ftw_ch0/ftw_ch1/asf_ch0/asf_ch1 inputs. Each output value is held for a programmable dwell time, so the downstream SPI engine sees a stable word long enough to ship it.

Parameters:
DWELL_W, 24, width of dwell-time field and dwell counter.
STEP_W, 16, width of step-count field and step counter.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a ramp (ignored while busy)
abort  in  1  single-cycle pulse; stops the ramp, outputs hold
ftw_start_ch0  in  32  ch0 initial tuning word
ftw_step_ch0  in  32  ch0 increment, two's complement
ftw_start_ch1  in  32  ch1 initial tuning word
ftw_step_ch1  in  32  ch1 increment, two's complement
asf_set_ch0  in  10  ch0 amplitude scale, constant for the ramp
asf_set_ch1  in  10  ch1 amplitude scale, constant for the ramp
num_steps  in  STEP_W  number of increments (N gives N+1 distinct values)
dwell  in  DWELL_W  clocks per value; 0 is treated as 1
ftw_ch0  out  32  to master ftw_ch0
ftw_ch1  out  32  to master ftw_ch1
asf_ch0  out  10  to master asf_ch0
asf_ch1  out  10  to master asf_ch1
busy  out  1  high while a ramp runs
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-low, named clock / reset_n.
- Reset: ftw_ch0 = ftw_ch1 = 0, asf_ch0 = asf_ch1 = 0, busy = 0, done = 0, FSM = IDLE, counters = 0.
- FSM states: IDLE and RUN. done is a registered flag, not a separate state.
- IDLE + start sampled high at edge k:
  - Latch step values, num_steps, and dwell_eff = (dwell == 0) ? 1 : dwell.
  - At edge k: ftw_chX <= ftw_start_chX, asf_chX <= asf_set_chX, busy <= 1, dwell_cnt <= 1, step_cnt <= 0, go to RUN.
- RUN, each edge:
  - If dwell_cnt < dwell_eff: dwell_cnt++.
  - Otherwise, if step_cnt == latched num_steps: busy <= 0, done <= 1 for one cycle, go to IDLE. Outputs hold the final value.
  - Otherwise: ftw_chX <= ftw_chX + step_chX (mod 2^32, wraps silently), step_cnt++, dwell_cnt <= 1.
- Timing: every value is visible for exactly dwell_eff cycles. Total busy time = (num_steps+1) * dwell_eff cycles.
- Inputs are sampled only at start. Changing them mid-ramp has no effect.
- asf outputs stay constant during a ramp.
- start while busy: ignored, no restart.
- abort in RUN: busy <= 0 next edge, done stays 0, ftw/asf hold their current values, go to IDLE.
- abort in IDLE: no effect.
- start and abort in the same cycle: in IDLE, start wins; in RUN, abort wins.
- Reset mid-ramp: immediate return to reset values at that edge. done is not asserted.
- A new start is accepted in the cycle after done (FSM is already IDLE).

Test Plan:
- Reset with all inputs nonzero -> all outputs 0, busy 0, done 0 for 5 cycles.
- ftw_start_ch0 = 0x1000_0000, step = 0x100, num_steps = 3, dwell = 4, start pulse -> ftw_ch0 sequence 0x1000_0000, 0x1000_0100, 0x1000_0200, 0x1000_0300, each held 4 cycles; busy high 16 cycles; done one pulse as busy falls; ftw_ch0 stays 0x1000_0300.
- ftw_start_ch1 = 0xFFFF_FFF0, step = 0x10, num_steps = 2, dwell = 0 -> ftw_ch1 = 0xFFFF_FFF0, 0x0000_0000, 0x0000_0010, one cycle each; busy 3 cycles.
- Negative step (0xFFFF_FF00) from 0x0000_1000, num_steps = 1, dwell = 2, with asf_set_ch0 = 0x3FF -> 0x0000_1000 then 0x0000_0F00; asf_ch0 = 0x3FF throughout.
- Abort in the 2nd dwell of a 5-step ramp -> busy low next cycle, no done pulse, ftw outputs hold the step-1 value; a second start mid-ramp has no effect.
- reset_n low mid-ramp for 1 cycle -> outputs 0, busy 0, done never asserted; a fresh start afterwards runs the full ramp.

Source files
------------

// File: rtl/ad9958_ramp_gen.sv
// ad9958_ramp_gen: stepped linear frequency ramps on both AD9958 channels,
// each word held for a programmable dwell so the SPI master can ship it.
module ad9958_ramp_gen #(
    parameter int DWELL_W = 24,
    parameter int STEP_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        ftw_start_ch0,
    input  logic [31:0]        ftw_step_ch0,
    input  logic [31:0]        ftw_start_ch1,
    input  logic [31:0]        ftw_step_ch1,
    input  logic [9:0]         asf_set_ch0,
    input  logic [9:0]         asf_set_ch1,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic [31:0]        ftw_ch0,
    output logic [31:0]        ftw_ch1,
    output logic [9:0]         asf_ch0,
    output logic [9:0]         asf_ch1,
    output logic               busy,
    output logic               done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [31:0] step0, step1;
    logic [STEP_W-1:0] steps_lat, step_cnt;
    logic [DWELL_W-1:0] dwell_eff, dwell_cnt;
    logic load, hold_tick, advance, finish;
    always_comb begin
        load      = state == IDLE && start;
        hold_tick = state == RUN && !abort && dwell_cnt < dwell_eff;
        finish    = state == RUN && !abort && dwell_cnt >= dwell_eff && step_cnt == steps_lat;
        advance   = state == RUN && !abort && dwell_cnt >= dwell_eff && step_cnt != steps_lat;
        state_nx  = load ? RUN : (state == RUN && (abort || finish)) ? IDLE : state;
    end
    assign busy = state == RUN;
    // Abort and completion both leave the output words untouched.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            ftw_ch0   <= '0;
            ftw_ch1   <= '0;
            asf_ch0   <= '0;
            asf_ch1   <= '0;
            done      <= 1'b0;
            step0     <= '0;
            step1     <= '0;
            steps_lat <= '0;
            step_cnt  <= '0;
            dwell_eff <= '0;
            dwell_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= finish;
            if (load) begin
                ftw_ch0   <= ftw_start_ch0;
                ftw_ch1   <= ftw_start_ch1;
                asf_ch0   <= asf_set_ch0;
                asf_ch1   <= asf_set_ch1;
                step0     <= ftw_step_ch0;
                step1     <= ftw_step_ch1;
                steps_lat <= num_steps;
                dwell_eff <= (dwell == '0) ? DWELL_W'(1) : dwell;
                dwell_cnt <= DWELL_W'(1);
                step_cnt  <= '0;
            end
            if (hold_tick)
                dwell_cnt <= dwell_cnt + 1'b1;
            if (advance) begin
                ftw_ch0   <= ftw_ch0 + step0;
                ftw_ch1   <= ftw_ch1 + step1;
                step_cnt  <= step_cnt + 1'b1;
                dwell_cnt <= DWELL_W'(1);
            end
        end
    end
endmodule
